// File: rtl/mips_data_mem.sv
// rtl/mips_data_mem.sv - MIPS data memory with cycle counter and transmit FIFO MMIO
//
// Purpose:
//    Word-organised data RAM with big-endian byte-lane writes and registered,
//    read-first loads. Addresses with mem_addr[31:16] == 16'hFFFF select a
//    small MMIO block instead of RAM:
//       0xFFFF0000 CYCLE  : free-running counter of enabled cycles, read-only
//       0xFFFF0004 TXDATA : write pushes mem_write_data[7:0] into the TX FIFO
//       0xFFFF0008 TXSTAT : {count[20:16], overflow[8], full[1], empty[0]}
//                           any write clears the sticky overflow bit
//
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    en                  CPU enable; gates writes, read capture and CYCLE
//    mem_addr            byte address
//    mem_write_en[3:0]   byte-lane write enables (bit 3 = bits 31:24)
//    mem_write_data      store data
//    mem_read_en         load request
//    mem_read_data       load data, valid one cycle after the request
//    tx_data, tx_valid   FIFO head byte and non-empty flag
//    tx_ready            consumer accepts the head byte

module mips_data_mem #(
   parameter int ADDR_WORDS_LOG2 = 10,
   parameter int TX_DEPTH        = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_write_en,
   input  logic [31:0] mem_write_data,
   input  logic        mem_read_en,
   output logic [31:0] mem_read_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int RAM_WORDS = 1 << ADDR_WORDS_LOG2;
   localparam int PTR_W     = $clog2(TX_DEPTH);
   localparam int CNT_W     = PTR_W + 1;

   localparam logic [15:0] OFF_CYCLE  = 16'h0000;
   localparam logic [15:0] OFF_TXDATA = 16'h0004;
   localparam logic [15:0] OFF_TXSTAT = 16'h0008;

   // Storage arrays; neither is reset.
   logic [31:0] ram_q  [RAM_WORDS];
   logic [7:0]  fifo_q [TX_DEPTH];

   logic [31:0]      rd_data_q, rd_data_d;
   logic [31:0]      cycle_q,   cycle_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
   logic             ovf_q,     ovf_d;

   logic                       is_mmio;
   logic [15:0]                mmio_off;
   logic [ADDR_WORDS_LOG2-1:0] ram_idx;
   logic                       any_we;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [4:0]                 count5;
   logic [31:0]                txstat;
   logic [31:0]                mmio_rdata;
   logic                       push;
   logic                       push_ok;
   logic                       pop;
   logic                       stat_clr;

   always_comb begin
      is_mmio    = (mem_addr[31:16] == 16'hFFFF);
      mmio_off   = mem_addr[15:0];
      ram_idx    = mem_addr[ADDR_WORDS_LOG2+1:2];
      any_we     = |mem_write_en;
      fifo_full  = (count_q == CNT_W'(TX_DEPTH));
      fifo_empty = (count_q == '0);
      count5     = 5'(count_q);
      txstat     = {11'b0, count5, 7'b0, ovf_q, 6'b0, fifo_full, fifo_empty};

      mmio_rdata = 32'h0;
      case (mmio_off)
         OFF_CYCLE:  mmio_rdata = cycle_q;
         OFF_TXSTAT: mmio_rdata = txstat;
         default:    mmio_rdata = 32'h0;
      endcase

      // Pop is independent of en so the consumer can drain while the CPU stalls.
      pop      = !fifo_empty && tx_ready;
      push     = en && is_mmio && (mmio_off == OFF_TXDATA) && any_we;
      // A full FIFO still accepts when the head leaves on the same edge.
      push_ok  = push && (!fifo_full || pop);
      stat_clr = en && is_mmio && (mmio_off == OFF_TXSTAT) && any_we;

      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      ovf_d = ovf_q;
      if (stat_clr) begin
         ovf_d = 1'b0;
      end else if (push && !push_ok) begin
         ovf_d = 1'b1;
      end

      cycle_d = en ? cycle_q + 32'd1 : cycle_q;

      // Sampling the array before the edge's write gives read-first behaviour.
      rd_data_d = rd_data_q;
      if (en && mem_read_en) begin
         rd_data_d = is_mmio ? mmio_rdata : ram_q[ram_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= 32'h0;
         cycle_q   <= 32'h0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         rd_data_q <= rd_data_d;
         cycle_q   <= cycle_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en && !is_mmio) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_write_en[i]) begin
               ram_q[ram_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
            end
         end
      end
   end

   // When full with a simultaneous pop, wr_ptr equals rd_ptr: the new byte
   // overwrites the departing head slot and becomes the tail.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_q[wr_ptr_q] <= mem_write_data[7:0];
      end
   end

   assign mem_read_data = rd_data_q;
   assign tx_valid      = !fifo_empty;
   assign tx_data       = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_mips_data_mem.sv
// tb/tb_mips_data_mem.sv - randomized and directed bench for mips_data_mem against a behavioural model

module tb_mips_data_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [31:0] mem_addr;
   logic [3:0]  mem_write_en;
   logic [31:0] mem_write_data;
   logic        mem_read_en;
   logic [31:0] mem_read_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] ram_m [1024];
   logic [7:0]  q_m [$];
   logic [31:0] cycle_m;
   logic        ovf_m;
   logic [31:0] rd_m;

   mips_data_mem #(.ADDR_WORDS_LOG2(10), .TX_DEPTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .mem_addr       (mem_addr),
      .mem_write_en   (mem_write_en),
      .mem_write_data (mem_write_data),
      .mem_read_en    (mem_read_en),
      .mem_read_data  (mem_read_data),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] stat_m();
      int c;
      c = q_m.size();
      return (32'(c) << 16) | (32'(ovf_m) << 8) | (32'(c == 4) << 1) | 32'(c == 0);
   endfunction

   // One clock cycle: drive inputs, advance the model, check outputs after the edge.
   task automatic cyc(input logic e, input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd, input logic re, input logic rdy);
      logic        mmio;
      logic [15:0] off;
      int          idx;
      int          sz;
      logic        pop;
      logic        push;
      logic [31:0] w;
      en = e; mem_addr = a; mem_write_en = we; mem_write_data = wd;
      mem_read_en = re; tx_ready = rdy;

      mmio = (a[31:16] == 16'hFFFF);
      off  = a[15:0];
      idx  = int'((a >> 2) & 32'h3FF);
      if (e && re) begin
         if (!mmio)               rd_m = ram_m[idx];
         else if (off == 16'h0)   rd_m = cycle_m;
         else if (off == 16'h8)   rd_m = stat_m();
         else                     rd_m = 32'h0;
      end
      sz   = q_m.size();
      pop  = (sz != 0) && rdy;
      push = e && mmio && (off == 16'h4) && (we != 4'b0);
      if (pop) void'(q_m.pop_front());
      if (push) begin
         if (sz < 4 || pop) q_m.push_back(wd[7:0]);
         else               ovf_m = 1'b1;
      end
      if (e && mmio && off == 16'h8 && we != 4'b0) ovf_m = 1'b0;
      if (e && !mmio) begin
         w = ram_m[idx];
         for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
         ram_m[idx] = w;
      end
      if (e) cycle_m = cycle_m + 32'd1;

      @(posedge clk);
      #1;
      chk("rdata", mem_read_data, rd_m);
      chk("tx_valid", 32'(tx_valid), 32'(q_m.size() != 0));
      chk("tx_data", 32'(tx_data), (q_m.size() != 0) ? 32'(q_m[0]) : 32'h0);
   endtask

   function automatic logic [31:0] rand_ram_addr();
      logic [15:0] hi;
      logic [3:0]  mid;
      logic [9:0]  w;
      logic [1:0]  b;
      hi  = 16'($urandom_range(0, 16'hFFFE));
      mid = 4'($urandom);
      w   = 10'(10'h080 + 10'($urandom_range(0, 15)));
      b   = 2'($urandom);
      return {hi, mid, w, b};
   endfunction

   initial begin
      logic [31:0] v0, v1, v2;
      logic [31:0] a;
      int          kind;
      logic        e, rdy, re;
      logic [3:0]  we;

      cycle_m = 0; ovf_m = 0; rd_m = 0;
      for (int i = 0; i < 1024; i++) ram_m[i] = 32'h0;
      rst_n = 1'b0; en = 0; mem_addr = 0; mem_write_en = 0; mem_write_data = 0;
      mem_read_en = 0; tx_ready = 0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset_rdata", mem_read_data, 32'h0);
      chk("reset_tx_valid", 32'(tx_valid), 32'h0);
      chk("reset_tx_data", 32'(tx_data), 32'h0);
      rst_n = 1'b1;

      // First CYCLE read after reset returns 0.
      cyc(1, 32'hFFFF0000, 4'h0, 32'h0, 1, 0);
      chk("cycle_first", mem_read_data, 32'h0);

      // Byte lanes
      cyc(1, 32'h100, 4'hF, 32'h11223344, 0, 0);
      cyc(1, 32'h100, 4'b0100, 32'hAAAAAAAA, 0, 0);
      cyc(1, 32'h100, 4'h0, 32'h0, 1, 0);
      chk("lanes", mem_read_data, 32'h11AA3344);

      // Read during write returns old contents
      cyc(1, 32'h40, 4'hF, 32'h0, 0, 0);
      cyc(1, 32'h40, 4'hF, 32'hDEADBEEF, 1, 0);
      chk("rdw_old", mem_read_data, 32'h0);
      cyc(1, 32'h40, 4'h0, 32'h0, 1, 0);
      chk("rdw_new", mem_read_data, 32'hDEADBEEF);

      // FIFO fill to overflow then drain
      for (int i = 0; i < 5; i++) cyc(1, 32'hFFFF0004, 4'b0001, 32'(8'h41 + i), 0, 0);
      cyc(1, 32'hFFFF0008, 4'h0, 32'h0, 1, 0);
      chk("fill_stat", mem_read_data, 32'h00040102);
      for (int i = 0; i < 4; i++) begin
         chk("drain", 32'(tx_data), 32'(8'h41 + i));
         cyc(1, 32'h0, 4'h0, 32'h0, 0, 1);
      end
      chk("drain_empty", 32'(tx_valid), 32'h0);

      // Push and pop together at full
      cyc(1, 32'hFFFF0008, 4'hF, 32'h0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 32'hFFFF0004, 4'b0001, 32'(8'h50 + i), 0, 0);
      cyc(1, 32'hFFFF0004, 4'b0001, 32'h54, 0, 1);
      cyc(1, 32'hFFFF0008, 4'h0, 32'h0, 1, 0);
      chk("pp_full_stat", mem_read_data, 32'h00040002);
      for (int i = 0; i < 4; i++) begin
         chk("pp_order", 32'(tx_data), 32'(8'h51 + i));
         cyc(1, 32'h0, 4'h0, 32'h0, 0, 1);
      end

      // en gating and counter
      cyc(1, 32'hFFFF0000, 4'h0, 32'h0, 1, 0);
      v0 = mem_read_data;
      for (int i = 0; i < 5; i++) cyc(0, 32'h100, 4'hF, 32'h55555555, 1, 0);
      cyc(1, 32'hFFFF0000, 4'h0, 32'h0, 1, 0);
      v1 = mem_read_data;
      chk("en_cycle_hold", v1 - v0, 32'd1);
      cyc(1, 32'h0, 4'h0, 32'h0, 0, 0);
      cyc(1, 32'h0, 4'h0, 32'h0, 0, 0);
      cyc(1, 32'hFFFF0000, 4'h0, 32'h0, 1, 0);
      v2 = mem_read_data;
      chk("cycle_delta3", v2 - v1, 32'd3);
      cyc(1, 32'h100, 4'h0, 32'h0, 1, 0);
      chk("en_write_ignored", mem_read_data, 32'h11AA3344);

      // Async reset with two bytes queued
      cyc(1, 32'hFFFF0004, 4'b0001, 32'h61, 0, 0);
      cyc(1, 32'hFFFF0004, 4'b0001, 32'h62, 0, 0);
      cyc(1, 32'h40, 4'h0, 32'h0, 1, 0);
      en = 0; mem_read_en = 0; mem_write_en = 0; tx_ready = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tx_valid", 32'(tx_valid), 32'h0);
      chk("arst_tx_data", 32'(tx_data), 32'h0);
      chk("arst_rdata", mem_read_data, 32'h0);
      q_m.delete(); cycle_m = 0; ovf_m = 0; rd_m = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1, 32'h40, 4'h0, 32'h0, 1, 0);
      chk("arst_ram_kept", mem_read_data, 32'hDEADBEEF);
      cyc(1, 32'hFFFF0000, 4'h0, 32'h0, 1, 0);
      chk("arst_cycle", mem_read_data, 32'h1);

      // Randomized traffic over 16 words with aliasing high address bits
      for (int k = 0; k < 16; k++) cyc(1, 32'h200 + 32'(4 * k), 4'hF, $urandom, 0, 0);
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 7);
         e    = ($urandom_range(0, 7) != 0);
         rdy  = ($urandom_range(0, 2) == 0);
         re   = 1'b0;
         we   = 4'h0;
         a    = rand_ram_addr();
         case (kind)
            0, 1: we = 4'($urandom);
            2, 3: begin re = 1'b1; we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0; end
            4:    begin a = 32'hFFFF0004; we = 4'($urandom_range(1, 15)); re = $urandom_range(0, 1) == 1; end
            5:    begin a = 32'hFFFF0000; re = 1'b1; we = 4'($urandom); end
            6:    begin a = 32'hFFFF0008; re = 1'b1; end
            default: begin
               a  = ($urandom_range(0, 1) == 1) ? 32'hFFFF0008 : 32'hFFFF000C;
               we = 4'($urandom);
               re = 1'b1;
            end
         endcase
         cyc(e, a, we, $urandom, re, rdy);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
